// File: rtl/div_request_sequencer_if.sv
// Handshake and pin bundle for div_request_sequencer: operand stream in, result stream out,
// plus the N/D drive pins and Q/R sense pins of the external 2-bit divider.
interface div_request_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_n;
    logic [1:0] in_d;

    logic       N1;
    logic       N0;
    logic       D1;
    logic       D0;
    logic       Q1;
    logic       Q0;
    logic       R1;
    logic       R0;

    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_q;
    logic [1:0] out_r;
    logic       out_err;

    modport master (
        output in_valid, in_n, in_d, out_ready, Q1, Q0, R1, R0,
        input  in_ready, N1, N0, D1, D0, out_valid, out_q, out_r, out_err
    );

    modport slave (
        input  in_valid, in_n, in_d, out_ready, Q1, Q0, R1, R0,
        output in_ready, N1, N0, D1, D0, out_valid, out_q, out_r, out_err
    );
endinterface

// File: rtl/div_request_sequencer.sv
// Sequences operand pairs through a 2-entry FIFO onto the combinational divider; result 1+SETTLE_CYCLES
// edges after accept. Backpressure: in_ready drops only when the FIFO is full; out_ready=0 holds the result.
module div_request_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    div_request_sequencer_if.slave  bus
);

    typedef struct packed {
        logic [1:0] n;
        logic [1:0] d;
    } pair_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    pair_t      fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;
    logic       push;
    logic       pop;
    pair_t      fifo_head;

    logic [1:0] state;
    logic [3:0] settle_cnt;
    pair_t      opnd;

    // in_ready depends on occupancy alone, so a pop in the same edge never admits a push into a full FIFO
    assign bus.in_ready = (fifo_count != 2'd2);
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_head    = fifo_mem[rd_ptr];

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = (fifo_count != 2'd0);
            ST_HOLD: pop = bus.out_ready && (fifo_count != 2'd0);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= pair_t'{n: bus.in_n, d: bus.in_d};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle_cnt  <= 4'd0;
            opnd        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_q     <= 2'd0;
            bus.out_r     <= 2'd0;
            bus.out_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        opnd       <= fifo_head;
                        settle_cnt <= SETTLE_LD;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        // A zero divisor never forwards the divider pins; remainder is the dividend
                        if (opnd.d == 2'd0) begin
                            bus.out_q   <= 2'd0;
                            bus.out_r   <= opnd.n;
                            bus.out_err <= 1'b1;
                        end else begin
                            bus.out_q   <= {bus.Q1, bus.Q0};
                            bus.out_r   <= {bus.R1, bus.R0};
                            bus.out_err <= 1'b0;
                        end
                        bus.out_valid <= 1'b1;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (pop) begin
                            opnd       <= fifo_head;
                            settle_cnt <= SETTLE_LD;
                            state      <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.N1 = opnd.n[1];
    assign bus.N0 = opnd.n[0];
    assign bus.D1 = opnd.d[1];
    assign bus.D0 = opnd.d[0];

endmodule

// File: tb/tb_div_request_sequencer.sv
// Scoreboard bench for div_request_sequencer: one instance at SETTLE_CYCLES=1, one at 3.
module tb_div_request_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_request_sequencer_if bus1();
    div_request_sequencer_if bus3();

    div_request_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    div_request_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // External divider model; drives 1111 on a zero divisor so any forwarding is visible
    function automatic logic [3:0] divmod(input logic [1:0] n, input logic [1:0] d);
        if (d == 2'd0) return 4'b1111;
        return {n / d, n % d};
    endfunction

    assign {bus1.Q1, bus1.Q0, bus1.R1, bus1.R0} = divmod({bus1.N1, bus1.N0}, {bus1.D1, bus1.D0});
    assign {bus3.Q1, bus3.Q0, bus3.R1, bus3.R0} = divmod({bus3.N1, bus3.N0}, {bus3.D1, bus3.D0});

    logic [4:0] exp1 [$];
    logic [4:0] exp3 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor for the SETTLE_CYCLES=1 instance: each handshake pops one expected {err,q,r}
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (exp1.size() == 0) check("res1_unexpected", 32'(bus1.out_valid), 32'd0);
            else check("res1", 32'({bus1.out_err, bus1.out_q, bus1.out_r}), 32'(exp1.pop_front()));
        end
    end

    logic [3:0] hist3 [3];
    logic       prev_v3 = 1'b0;
    int         nrise3 = 0;
    int         last_rise3 = 0;

    always @(negedge clk) begin
        logic [3:0] pins3;
        pins3 = {bus3.N1, bus3.N0, bus3.D1, bus3.D0};
        if (rst_n && bus3.out_valid && !prev_v3) begin
            check("pins3_stable", 32'({hist3[0] == pins3, hist3[1] == pins3, hist3[2] == pins3}), 32'd7);
            if (nrise3 > 0) check("gap3", 32'(cyc - last_rise3), 32'd4);
            last_rise3 = cyc;
            nrise3++;
        end
        if (rst_n && bus3.out_valid && bus3.out_ready) begin
            if (exp3.size() == 0) check("res3_unexpected", 32'(bus3.out_valid), 32'd0);
            else check("res3", 32'({bus3.out_err, bus3.out_q, bus3.out_r}), 32'(exp3.pop_front()));
        end
        prev_v3  = bus3.out_valid;
        hist3[2] = hist3[1];
        hist3[1] = hist3[0];
        hist3[0] = pins3;
    end

    task automatic push_op1(input logic [1:0] n, input logic [1:0] d, input logic [4:0] e);
        bit acc = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_n     = n;
        bus1.in_d     = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus1.in_ready;
        end
        check("push1_ready", 32'(bus1.in_ready), 32'd1);
        if (acc) exp1.push_back(e);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic push_op3(input logic [1:0] n, input logic [1:0] d, input logic [4:0] e);
        bit acc = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.in_n     = n;
        bus3.in_d     = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus3.in_ready;
        end
        check("push3_ready", 32'(bus3.in_ready), 32'd1);
        if (acc) exp3.push_back(e);
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
    endtask

    task automatic drain1();
        for (int i = 0; i < 200 && exp1.size() != 0; i++) @(posedge clk);
        check("drain1", 32'(exp1.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain3();
        for (int i = 0; i < 200 && exp3.size() != 0; i++) @(posedge clk);
        check("drain3", 32'(exp3.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_n = 2'd3; bus1.in_d = 2'd2; bus1.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_n = 2'd0; bus3.in_d = 2'd0; bus3.out_ready = 1'b1;

        // Reset held with in_valid asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
            check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
            check("rst_pins", 32'({bus1.N1, bus1.N0, bus1.D1, bus1.D0}), 32'd0);
        end
        check("rst_out_data", 32'({bus1.out_err, bus1.out_q, bus1.out_r}), 32'd0);
        rst_n = 1'b1;
        exp1.push_back({1'b0, 2'd1, 2'd1});

        // Single op 3/2: accepted at E0, pins at E1, result at E2
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk); check("lat_e0_valid", 32'(bus1.out_valid), 32'd0);
        @(negedge clk); check("lat_e1_valid", 32'(bus1.out_valid), 32'd0);
        check("lat_e1_pins", 32'({bus1.N1, bus1.N0, bus1.D1, bus1.D0}), 32'b1110);
        @(negedge clk); check("lat_e2_valid", 32'(bus1.out_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("hold_result", 32'({bus1.out_valid, bus1.out_err, bus1.out_q, bus1.out_r}), 32'b100101);
        end
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("clear_after_ready", 32'(bus1.out_valid), 32'd0);
        check("single_consumed", 32'(exp1.size()), 32'd0);

        // Divide by zero, then a normal op
        push_op1(2'd2, 2'd0, {1'b1, 2'd0, 2'd2});
        push_op1(2'd1, 2'd3, {1'b0, 2'd0, 2'd1});
        drain1();

        // Backpressure: three fill the pipeline, the fourth stalls until a result is taken
        bus1.out_ready = 1'b0;
        push_op1(2'd3, 2'd1, {1'b0, 2'd3, 2'd0});
        push_op1(2'd2, 2'd1, {1'b0, 2'd2, 2'd0});
        push_op1(2'd1, 2'd3, {1'b0, 2'd0, 2'd1});
        bus1.in_valid = 1'b1; bus1.in_n = 2'd3; bus1.in_d = 2'd3;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus1.in_ready), 32'd0);
            check("full_out_valid", 32'(bus1.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        push_op1(2'd3, 2'd3, {1'b0, 2'd1, 2'd0});
        drain1();

        // Back-to-back at SETTLE_CYCLES=3
        push_op3(2'd3, 2'd2, {1'b0, 2'd1, 2'd1});
        push_op3(2'd2, 2'd1, {1'b0, 2'd2, 2'd0});
        push_op3(2'd3, 2'd3, {1'b0, 2'd1, 2'd0});
        drain3();
        check("rises3", 32'(nrise3), 32'd3);

        // Reset during DRIVE of (3,2) with (2,1) queued
        repeat (3) @(posedge clk);
        #1;
        bus1.in_valid = 1'b1; bus1.in_n = 2'd3; bus1.in_d = 2'd2;
        @(posedge clk); #1;
        bus1.in_n = 2'd2; bus1.in_d = 2'd1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus1.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus1.in_ready), 32'd1);
        check("midrst_pins", 32'({bus1.N1, bus1.N0, bus1.D1, bus1.D0}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(bus1.out_valid), 32'd0);
        end
        push_op1(2'd1, 2'd1, {1'b0, 2'd1, 2'd0});
        drain1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/div_request_sequencer.md
# div_request_sequencer

Sequential front end for the 2-bit combinational division circuit. It accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry FIFO. It drives each pair onto the divider's N1/N0/D1/D0 pins, waits a programmable settle time, then captures Q1/Q0/R1/R0 into a result register with a valid/ready output handshake. Divide-by-zero is intercepted here; the divider's outputs for D=0 are never forwarded.

## Interface
- SETTLE_CYCLES, 1: cycles operands are held on the divider pins before capture; legal range 1..15 (4-bit counter).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  FIFO can accept; equals (fifo_count != 2).
- in_n  in  2  dividend, bit 1 = N1.
- in_d  in  2  divisor, bit 1 = D1.
- N1, N0, D1, D0  out  1 each  operand pins to the division circuit; driven from the operand register.
- Q1, Q0, R1, R0  in  1 each  quotient/remainder from the division circuit.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts result.
- out_q  out  2  quotient, bit 1 = Q1.
- out_r  out  2  remainder, bit 1 = R1.
- out_err  out  1  result came from a divisor of 0.

## Operation
- Reset values: FIFO empty (in_ready=1), operand register 0 (N1..D0 = 0), out_valid=0, out_q=0, out_r=0, out_err=0, state IDLE, settle counter 0.
- FIFO: 2 entries of {n,d}, strict order. Push occurs on in_valid && in_ready. Pop is issued by the FSM. A simultaneous push and pop when full is legal because in_ready is computed before the pop, so the push is refused. A simultaneous push and pop at count 1 leaves count at 1.
- IDLE: if the FIFO is non-empty, pop into the operand register, load counter=SETTLE_CYCLES, and go to DRIVE. Otherwise stay; the divider pins hold their last operands.
- DRIVE: decrement the counter each cycle. On the cycle the counter reads 1, go to CAPTURE behaviour at that edge.
  - D != 0: out_q <= {Q1,Q0}, out_r <= {R1,R0}, out_err <= 0.
  - D == 0: out_q <= 0, out_r <= stored N, out_err <= 1.
  - In both cases set out_valid <= 1 and go to HOLD.
- HOLD: out_* are stable while out_valid=1 and out_ready=0. When out_ready=1:
  - out_valid <= 0.
  - If the FIFO is non-empty, pop into the operand register, reload the counter, and go to DRIVE in the same edge.
  - Otherwise go to IDLE.
- Operands change only on a pop. The divider pins never change while in DRIVE.
- Reset asserted mid-operation clears the FIFO, the in-flight operand and any pending result immediately and asynchronously. No result is emitted for work accepted before reset.

## Timing
- Accept at edge E0 with FIFO empty and FSM in IDLE:
  - pop and pins update at E1;
  - capture at E(1+SETTLE_CYCLES);
  - out_valid is high from that edge.
  - With the default setting, out_valid rises 2 edges after acceptance.
- Sustained throughput with out_ready=1: one result per SETTLE_CYCLES+1 cycles. out_valid is high 1 cycle, then low SETTLE_CYCLES cycles.
- Storage: at most 3 pairs outstanding (2 in the FIFO + 1 in the operand register/result path). A 4th push stalls until a pop.
- in_ready is combinational from fifo_count only. It has no path from out_ready.
- out_valid, out_q, out_r and out_err are registered outputs.

## Test plan
- Reset with in_valid=1 held: in_ready=1, out_valid=0, and N1..D0=0 throughout. Release rst_n: first push accepted at the next edge.
- Single op N=3, D=2, SETTLE_CYCLES=1: out_valid rises 2 edges after accept, with out_q=1, out_r=1, out_err=0. The result holds for 3 cycles with out_ready=0 and clears 1 edge after out_ready=1.
- Divide-by-zero N=2, D=0: out_q=0, out_r=2, out_err=1. The next op, N=1, D=3, gives out_q=0, out_r=1, out_err=0.
- Backpressure with out_ready=0: push (3,1), (2,1), (1,3), (3,3). The fourth push sees in_ready=0 until the first result is taken. With out_ready=1, results come out in order: (3,0), (2,0), (0,1), (1,0).
- Back-to-back with out_ready=1 and SETTLE_CYCLES=3: out_valid pulses are 4 cycles apart, and the pins are stable for all 3 DRIVE cycles.
- Assert rst_n low for one cycle during DRIVE of (3,2) with (2,1) still queued: out_valid stays 0 and in_ready=1. After release, no stale result appears and a fresh push (1,1) yields out_q=1, out_r=0.
